// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of the pixel-enable input and the timing outputs of vga_timing_gen.
//
//   pix_ce      : pixel clock enable into the generator
//   hsync       : horizontal sync, active at H_POL
//   vsync       : vertical sync, active at V_POL
//   VGA_sync    : composite sync, active-low
//   VGA_blank   : active-low blank, 1 while the RGB output is driven
//   pix_x/pix_y : column/row of the current pixel (CW bits)
//   line_start  : one-cycle pulse at column 0
//   frame_start : one-cycle pulse at column 0, row 0
//   frame_cnt   : 16-bit frame counter, present only when the macro
//                 VGA_TIMING_FRAME_CNT_EN is defined
//
// master modport: the timing generator.  slave modport: the display pipeline.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          pix_ce;
  logic          hsync;
  logic          vsync;
  logic          VGA_sync;
  logic          VGA_blank;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  modport master (
    input  pix_ce,
    output hsync, vsync, VGA_sync, VGA_blank, pix_x, pix_y,
           line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_ce,
    input  hsync, vsync, VGA_sync, VGA_blank, pix_x, pix_y,
           line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parameterised VGA raster timing generator.  A horizontal counter walks the
// columns of a line and a vertical counter walks the lines of a frame; both
// advance only on pix_ce cycles.  All outputs are registered decodes of the
// counter state seen on the previous pix_ce cycle, so they are mutually
// aligned with one cycle of latency.
//
// Ports:
//   clk  : pixel clock
//   rst  : synchronous reset, active-high, has priority over pix_ce
//   vga  : vga_timing_gen_if.master (pix_ce in; hsync, vsync, VGA_sync,
//          VGA_blank, pix_x, pix_y, line_start, frame_start out)
//
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit
// free-running frame_cnt output, which increments on each frame_start pulse.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VIS  = 1280,
  parameter int H_FP   = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP   = 248,
  parameter int V_VIS  = 1024,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 38,
  parameter bit H_POL  = 1'b1,
  parameter bit V_POL  = 1'b1,
  parameter int CW     = 11
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // Totals must be representable in CW bits, otherwise the counters would
  // silently alias; stop elaboration instead.
  if (H_TOT >= (1 << CW)) begin : g_h_tot_too_wide
    $error("vga_timing_gen: H_TOT=%0d does not fit in CW=%0d bits", H_TOT, CW);
  end
  if (V_TOT >= (1 << CW)) begin : g_v_tot_too_wide
    $error("vga_timing_gen: V_TOT=%0d does not fit in CW=%0d bits", V_TOT, CW);
  end

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VIS);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_VIS + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          csync_q, csync_d;
  logic          blank_q, blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic h_in_sync;
  logic v_in_sync;
  logic in_visible;

  // Decodes of the current counter state; they become the outputs on the
  // next pix_ce edge.
  assign h_in_sync  = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
  assign v_in_sync  = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
  assign in_visible = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);

  // Next-state for counters and output registers.  Without pix_ce every
  // level output holds while the pulses drop to 0.  v_cnt only moves on the
  // h_cnt wrap, so vsync edges always land on the column-0 output cycle.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    csync_d       = csync_q;
    blank_d       = blank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (vga.pix_ce) begin
      pix_x_d       = h_cnt_q;
      pix_y_d       = v_cnt_q;
      hsync_d       = h_in_sync ? H_POL : ~H_POL;
      vsync_d       = v_in_sync ? V_POL : ~V_POL;
      csync_d       = ~(h_in_sync | v_in_sync);
      blank_d       = in_visible;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      csync_q       <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.VGA_sync    = csync_q;
  assign vga.VGA_blank   = blank_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Steps together with the frame_start register so the new count is
  // visible on the same cycle as the pulse; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen on a 16x8 raster.  The reference
// model tracks a linear pixel index within the frame and derives column/row,
// sync and blank from it with plain arithmetic.  Define
// VGA_TIMING_FRAME_CNT_EN to also check the frame counter.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_VIS  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 3;
  localparam int H_BP   = 3;
  localparam int V_VIS  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam bit H_POL  = 1'b0;
  localparam bit V_POL  = 1'b0;
  localparam int CW     = 11;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_timing_gen_if #(.CW(CW)) vif ();

  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  always #5 clk = ~clk;

  int nCmp  = 0;
  int nFail = 0;

  // Reference model state: index of the pixel the next pix_ce cycle shows,
  // plus the outputs currently expected.
  int          nextPos;
  int          eX;
  int          eY;
  logic        eHs;
  logic        eVs;
  logic        eSync;
  logic        eBlank;
  logic        eLs;
  logic        eFs;
  logic [15:0] eFc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelUpdate(input logic ce, input logic r);
    bit hAct;
    bit vAct;
    if (r) begin
      nextPos = 0;
      eX = 0; eY = 0;
      eHs = !H_POL; eVs = !V_POL;
      eSync = 1'b1; eBlank = 1'b0;
      eLs = 1'b0; eFs = 1'b0;
      eFc = 16'd0;
    end else if (ce) begin
      eX     = nextPos % H_TOT;
      eY     = nextPos / H_TOT;
      hAct   = (eX >= H_VIS + H_FP) && (eX < H_VIS + H_FP + H_SYNC);
      vAct   = (eY >= V_VIS + V_FP) && (eY < V_VIS + V_FP + V_SYNC);
      eHs    = hAct ? H_POL : !H_POL;
      eVs    = vAct ? V_POL : !V_POL;
      eSync  = !(hAct || vAct);
      eBlank = (eX < H_VIS) && (eY < V_VIS);
      eLs    = (eX == 0);
      eFs    = (nextPos == 0);
      if (eFs) eFc = eFc + 16'd1;
      nextPos = (nextPos + 1) % FRAME;
    end else begin
      eLs = 1'b0;
      eFs = 1'b0;
    end
  endfunction

  // Drive inputs, clock once, advance the model, then settle away from the edge.
  task automatic applyStimulus(input logic ce, input logic r);
    vif.pix_ce = ce;
    rst        = r;
    @(posedge clk);
    modelUpdate(ce, r);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".pix_x"},       32'(vif.pix_x),       32'(eX));
    chk({tag, ".pix_y"},       32'(vif.pix_y),       32'(eY));
    chk({tag, ".hsync"},       32'(vif.hsync),       32'(eHs));
    chk({tag, ".vsync"},       32'(vif.vsync),       32'(eVs));
    chk({tag, ".VGA_sync"},    32'(vif.VGA_sync),    32'(eSync));
    chk({tag, ".VGA_blank"},   32'(vif.VGA_blank),   32'(eBlank));
    chk({tag, ".line_start"},  32'(vif.line_start),  32'(eLs));
    chk({tag, ".frame_start"}, 32'(vif.frame_start), 32'(eFs));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk({tag, ".frame_cnt"},   32'(vif.frame_cnt),   32'(eFc));
`endif
  endtask

  initial begin
    int   hsLow;
    int   vsLow;
    int   blankCnt;
    int   fsCnt;
    int   firstFs;
    int   secondFs;
    int   guard;
    logic prevLs;

    vif.pix_ce = 1'b0;

    // Reset state, with pix_ce both high and low during reset.
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset");
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_hold");
    chk("reset.hsync_inactive", 32'(vif.hsync), 32'd1);
    chk("reset.VGA_blank", 32'(vif.VGA_blank), 32'd0);

    // Free-run two frames with pix_ce=1; collect counts over the first frame.
    hsLow = 0; vsLow = 0; blankCnt = 0; fsCnt = 0; firstFs = -1; secondFs = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("freerun");
      if (i < FRAME) begin
        if (vif.hsync == 1'b0) hsLow++;
        if (vif.vsync == 1'b0) vsLow++;
        if (vif.VGA_blank == 1'b1) blankCnt++;
        if (vif.frame_start == 1'b1) fsCnt++;
      end
      if (vif.frame_start == 1'b1) begin
        if (firstFs < 0) firstFs = i;
        else if (secondFs < 0) secondFs = i;
      end
    end
    chk("freerun.hsync_low_cycles", 32'(hsLow), 32'd24);
    chk("freerun.vsync_low_cycles", 32'(vsLow), 32'd32);
    chk("freerun.blank_cycles", 32'(blankCnt), 32'd32);
    chk("freerun.frame_start_count", 32'(fsCnt), 32'd1);
    chk("freerun.frame_period", 32'(secondFs - firstFs), 32'(FRAME));

    // pix_ce toggling 1,0,1,0: one frame now spans 256 clocks.
    applyStimulus(1'b0, 1'b1);
    checkOutput("toggle_reset");
    prevLs = 1'b0; firstFs = -1; secondFs = -1;
    for (int k = 0; k < 4 * FRAME; k++) begin
      applyStimulus((k % 2) == 0, 1'b0);
      checkOutput("toggle");
      chk("toggle.line_start_double", 32'(prevLs && vif.line_start), 32'd0);
      prevLs = vif.line_start;
      if (vif.frame_start == 1'b1) begin
        if (firstFs < 0) firstFs = k;
        else if (secondFs < 0) secondFs = k;
      end
    end
    chk("toggle.frame_period", 32'(secondFs - firstFs), 32'(2 * FRAME));

    // Reset asserted at (11,5), inside both sync pulses, with pix_ce=1.
    applyStimulus(1'b0, 1'b1);
    guard = 0;
    while (!(vif.pix_x == 11 && vif.pix_y == 5) && guard < 2 * FRAME) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst_mid_sync.run");
      guard++;
    end
    chk("rst_mid_sync.reach_x", 32'(vif.pix_x), 32'd11);
    chk("rst_mid_sync.reach_y", 32'(vif.pix_y), 32'd5);
    chk("rst_mid_sync.hsync_active", 32'(vif.hsync), 32'd0);
    chk("rst_mid_sync.vsync_active", 32'(vif.vsync), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_mid_sync.reset");
    chk("rst_mid_sync.hsync", 32'(vif.hsync), 32'd1);
    chk("rst_mid_sync.vsync", 32'(vif.vsync), 32'd1);
    chk("rst_mid_sync.VGA_blank", 32'(vif.VGA_blank), 32'd0);
    chk("rst_mid_sync.pix_x", 32'(vif.pix_x), 32'd0);
    chk("rst_mid_sync.pix_y", 32'(vif.pix_y), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_mid_sync.idle");
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_mid_sync.first_ce");
    chk("rst_mid_sync.frame_start", 32'(vif.frame_start), 32'd1);
    chk("rst_mid_sync.line_start", 32'(vif.line_start), 32'd1);
    chk("rst_mid_sync.VGA_blank_on", 32'(vif.VGA_blank), 32'd1);

    // Boundary: last pixel of the frame, a held cycle, then the wrap.
    guard = 0;
    while (!(vif.pix_x == 15 && vif.pix_y == 7) && guard < 2 * FRAME) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("boundary.run");
      guard++;
    end
    chk("boundary.reach_x", 32'(vif.pix_x), 32'd15);
    chk("boundary.reach_y", 32'(vif.pix_y), 32'd7);
    applyStimulus(1'b0, 1'b0);
    checkOutput("boundary.hold");
    applyStimulus(1'b1, 1'b0);
    checkOutput("boundary.wrap");
    chk("boundary.pix_x", 32'(vif.pix_x), 32'd0);
    chk("boundary.pix_y", 32'(vif.pix_y), 32'd0);
    chk("boundary.line_start", 32'(vif.line_start), 32'd1);
    chk("boundary.frame_start", 32'(vif.frame_start), 32'd1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Three frames from reset: frame_cnt reads 1,2,3 at the pulses.
    applyStimulus(1'b0, 1'b1);
    checkOutput("fcnt_reset");
    fsCnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("fcnt");
      if (vif.frame_start == 1'b1) begin
        fsCnt++;
        chk("fcnt.at_frame_start", 32'(vif.frame_cnt), 32'(fsCnt));
      end
    end
    chk("fcnt.pulses", 32'(fsCnt), 32'd3);
    applyStimulus(1'b1, 1'b1);
    chk("fcnt.after_reset", 32'(vif.frame_cnt), 32'd0);
`endif

    // Random pix_ce with occasional resets against the model.
    applyStimulus(1'b0, 1'b1);
    checkOutput("random_reset");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters:
- H_VIS, default 1280: visible pixels per line.
- H_FP, default 48: horizontal front porch, in pixels.
- H_SYNC, default 112: horizontal sync width, in pixels.
- H_BP, default 248: horizontal back porch, in pixels.
- V_VIS, default 1024: visible lines per frame.
- V_FP, default 1: vertical front porch, in lines.
- V_SYNC, default 3: vertical sync width, in lines.
- V_BP, default 38: vertical back porch, in lines.
- H_POL, default 1: hsync active level; 1 means active-high, 0 means active-low.
- V_POL, default 1: vsync active level; same encoding as H_POL.
- CW, default 11: counter and coordinate width.

REQ-002 The block SHALL have these ports, all synchronous to clk:
- clk, input, 1: pixel clock.
- rst, input, 1: synchronous reset, active-high.
- pix_ce, input, 1: pixel clock enable.
- hsync, output, 1: horizontal sync at H_POL level.
- vsync, output, 1: vertical sync at V_POL level.
- VGA_sync, output, 1: composite sync, active-low.
- VGA_blank, output, 1: active-low blank; 1 means the RGB output is driven.
- pix_x, output, CW: column of the current pixel.
- pix_y, output, CW: row of the current pixel.
- line_start, output, 1: one-cycle pulse at column 0.
- frame_start, output, 1: one-cycle pulse at column 0, row 0.

REQ-003 H_TOT SHALL be H_VIS+H_FP+H_SYNC+H_BP and V_TOT SHALL be V_VIS+V_FP+V_SYNC+V_BP; both SHALL fit in CW bits, otherwise elaboration SHALL fail.

Function
REQ-004 Internal counter h_cnt SHALL count 0..H_TOT-1 and advance only on cycles with pix_ce=1.
REQ-005 When h_cnt=H_TOT-1 and pix_ce=1, h_cnt SHALL wrap to 0 and v_cnt SHALL advance.
REQ-006 v_cnt SHALL count 0..V_TOT-1 and wrap to 0 after V_TOT-1; no value of H_TOT or V_TOT SHALL ever be emitted.
REQ-007 All outputs SHALL be registered and mutually aligned, each reflecting the counter state of the previous pix_ce cycle (1-cycle latency); pix_x=h_cnt and pix_y=v_cnt.
REQ-008 hsync SHALL be at H_POL when h_cnt is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], and at ~H_POL otherwise.
REQ-009 vsync SHALL be at V_POL when v_cnt is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], and at ~V_POL otherwise; vsync transitions occur on the same cycle as h_cnt=0.
REQ-010 VGA_blank SHALL be 1 only when h_cnt<H_VIS and v_cnt<V_VIS.
REQ-011 VGA_sync SHALL be 0 when either hsync or vsync is active, and 1 otherwise.
REQ-012 line_start SHALL be 1 for exactly one cycle, the cycle reflecting h_cnt=0.
REQ-013 frame_start SHALL be 1 for exactly one cycle, the cycle reflecting h_cnt=0 and v_cnt=0.
REQ-014 On cycles with pix_ce=0, counters and all level outputs SHALL hold, and line_start and frame_start SHALL be 0.

Reset
REQ-015 rst=1 on a clock edge SHALL clear h_cnt and v_cnt to 0, force hsync=~H_POL and vsync=~V_POL, and set VGA_sync=1, VGA_blank=0, pix_x=0, pix_y=0, line_start=0 and frame_start=0.
REQ-016 rst SHALL take priority over pix_ce, including when asserted mid-line or mid-sync.
REQ-017 After rst deasserts, the first pix_ce=1 cycle SHALL produce outputs for position (0,0) with line_start=1, frame_start=1 and VGA_blank=1.

Configuration
REQ-018 With macro VGA_TIMING_FRAME_CNT_EN defined, the block SHALL add output frame_cnt [15:0], which resets to 0, increments on every frame_start pulse, and wraps from 65535 to 0.
REQ-019 Without VGA_TIMING_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
Small configuration used by all scenarios: H_VIS=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOT=16); V_VIS=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOT=8); H_POL=0, V_POL=0.
REQ-020 Free-run with pix_ce=1 -> the bench SHALL check:
- hsync=0 exactly at pix_x 10..12.
- VGA_blank=1 exactly at pix_x 0..7 with pix_y 0..3.
- The frame repeats every 128 cycles.
REQ-021 Free-run -> the bench SHALL check:
- vsync=0 exactly for pix_y 5..6, 32 cycles in total.
- VGA_sync=0 whenever hsync=0 or vsync=0.
- No frame_start occurs except at (0,0).
REQ-022 pix_ce toggling 1,0,1,0 -> the bench SHALL check:
- Outputs advance one pixel per pix_ce=1 cycle.
- A full frame takes 256 clocks.
- line_start never stays high for 2 cycles.
REQ-023 rst asserted at (pix_x=11, pix_y=5), during both syncs, with pix_ce=1 -> the bench SHALL check:
- The next cycle shows hsync=1, vsync=1, VGA_blank=0 and position (0,0).
- After release, the first pix_ce cycle shows frame_start=1.
REQ-024 Boundary check at pix_x=15, pix_y=7 -> the next pix_ce cycle SHALL show pix_x=0, pix_y=0, line_start=1 and frame_start=1.
REQ-025 With VGA_TIMING_FRAME_CNT_EN defined, run 3 frames -> frame_cnt SHALL read 1, 2, 3 at successive frame_start pulses, and 0 after rst.
